// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD requester front end.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } gcd_req_state_t;

endpackage

// File: rtl/gcd_req_counter.sv
// Clearable, saturating WAIT-cycle counter with a limit compare for the watchdog.
module gcd_req_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LIMIT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count_inc,
  output logic             at_limit
);

  localparam logic [63:0] MaxCount = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] LimitM1  = 64'(LIMIT) - 64'd1;
  // A limit beyond saturation collapses onto the saturated value so the compare still fires.
  localparam logic [CNT_W-1:0] CmpVal =
      (LimitM1 > MaxCount) ? {CNT_W{1'b1}} : LimitM1[CNT_W-1:0];

  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    at_limit  = (count_q >= CmpVal);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_inc;
    end
  end

endmodule

// File: rtl/gcd_requester.sv
// Initiator front end for the GCD engine: request/response handshakes, zero bypass, cycle count.
// Define GCD_REQ_TIMEOUT_EN to build the WAIT watchdog.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH   = GCD_WIDTH,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic             eng_start,
  input  logic [WIDTH-1:0] eng_result,
  input  logic             eng_done
);

  gcd_req_state_t   state_q;
  logic             req_ready_q, rsp_valid_q, rsp_err_q, eng_start_q;
  logic [WIDTH-1:0] rsp_gcd_q, eng_a_q, eng_b_q;
  logic [CNT_W-1:0] rsp_cycles_q;
  logic [CNT_W-1:0] count_inc;
  logic             at_limit;
  logic             timeout_hit;

  gcd_req_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == ISSUE),
    .enable    (state_q == WAIT),
    .count_inc (count_inc),
    .at_limit  (at_limit)
  );

`ifdef GCD_REQ_TIMEOUT_EN
  assign timeout_hit = at_limit;
`else
  logic unused_at_limit;
  assign unused_at_limit = at_limit;
  assign timeout_hit     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      eng_start_q  <= 1'b0;
      rsp_gcd_q    <= '0;
      rsp_cycles_q <= '0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          // req_ready_q is low for the first cycle after reset, so nothing is taken then.
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            eng_a_q     <= req_a;
            eng_b_q     <= req_b;
            if (req_a == '0 || req_b == '0) begin
              rsp_gcd_q    <= req_a | req_b;
              rsp_cycles_q <= '0;
              rsp_err_q    <= 1'b0;
              rsp_valid_q  <= 1'b1;
              state_q      <= HOLD;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          eng_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_gcd_q    <= eng_result;
            rsp_cycles_q <= count_inc;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end else if (timeout_hit) begin
            rsp_gcd_q    <= '0;
            rsp_cycles_q <= count_inc;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_gcd    = rsp_gcd_q;
  assign rsp_cycles = rsp_cycles_q;
  assign eng_a      = eng_a_q;
  assign eng_b      = eng_b_q;
  assign eng_start  = eng_start_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a latency-programmable engine model.
module tb_gcd_requester;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0] rsp_gcd;
  logic [CNT_W-1:0] rsp_cycles;
  logic [WIDTH-1:0] eng_a, eng_b, eng_result;
  logic             eng_start, eng_done;

  logic             model_done, inject_done;
  logic             busy;
  int               left;
  int               eng_lat;
  logic [WIDTH-1:0] res_hold;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  gcd_requester #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gcd    (rsp_gcd),
    .rsp_err    (rsp_err),
    .rsp_cycles (rsp_cycles),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_start  (eng_start),
    .eng_result (eng_result),
    .eng_done   (eng_done)
  );

  function automatic logic [WIDTH-1:0] euclid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: done arrives eng_lat edges after start is sampled; eng_lat = 0 never completes.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (reset) begin
      busy <= 1'b0;
      left <= 0;
    end else if (eng_start) begin
      busy     <= (eng_lat != 0);
      left     <= eng_lat;
      res_hold <= euclid(eng_a, eng_b);
    end else if (busy) begin
      if (left <= 1) begin
        model_done <= 1'b1;
        eng_result <= res_hold;
        busy       <= 1'b0;
      end else begin
        left <= left - 1;
      end
    end
  end

  assign eng_done = model_done | inject_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request/response; exp_wait is the negedge index (1 = cycle after acceptance) of rsp_valid.
  task automatic txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int lat,
                     input logic [WIDTH-1:0] exp_gcd, input logic [CNT_W-1:0] exp_cyc,
                     input logic exp_err, input int exp_wait, input int hold);
    int n;
    int starts;
    eng_lat = lat;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("eng_a", eng_a, a);
    check_eq("eng_b", eng_b, b);
    check_eq("req_ready_busy", req_ready, 0);
    starts = eng_start ? 1 : 0;
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (eng_start) starts++;
    end
    check_eq("rsp_latency", n, exp_wait);
    check_eq("eng_start_count", starts, (a == 0 || b == 0) ? 0 : 1);
    check_eq("rsp_gcd", rsp_gcd, exp_gcd);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("rsp_cycles", rsp_cycles, exp_cyc);
    for (int i = 0; i < hold; i++) begin
      inject_done = (i % 2 == 0);
      @(negedge clk);
      inject_done = 1'b0;
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_gcd", rsp_gcd, exp_gcd);
      check_eq("hold_cycles", rsp_cycles, exp_cyc);
      check_eq("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_req_ready", req_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_err"}, rsp_err, 0);
    check_eq({tag, "_eng_start"}, eng_start, 0);
    check_eq({tag, "_rsp_gcd"}, rsp_gcd, 0);
    check_eq({tag, "_rsp_cycles"}, rsp_cycles, 0);
    check_eq({tag, "_eng_a"}, eng_a, 0);
    check_eq({tag, "_eng_b"}, eng_b, 0);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;
    inject_done = 1'b0;
    eng_lat     = 1;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check_eq("req_ready_after_reset", req_ready, 1);

    // 48,18 with done in WAIT cycle 3.
    txn(32'd48, 32'd18, 2, 32'd6, 4'd3, 1'b0, 5, 0);
    // Zero bypasses.
    txn(32'd0, 32'd7, 1, 32'd7, 4'd0, 1'b0, 1, 0);
    txn(32'd0, 32'd0, 1, 32'd0, 4'd0, 1'b0, 1, 0);
    txn(32'd9, 32'd0, 1, 32'd9, 4'd0, 1'b0, 1, 0);
    // Back-pressure with stray done pulses.
    txn(32'd17, 32'd5, 1, 32'd1, 4'd2, 1'b0, 4, 5);

`ifdef GCD_REQ_TIMEOUT_EN
    // Engine never completes: abort after TIMEOUT WAIT cycles.
    txn(32'd12, 32'd8, 0, 32'd0, 4'd8, 1'b1, 10, 2);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    @(negedge clk);
    check_eq("late_done_ignored", rsp_valid, 0);
`else
    // Counter saturates at 15 for a done in WAIT cycle 21.
    txn(32'd12, 32'd8, 20, 32'd4, 4'd15, 1'b0, 23, 0);
`endif

    // Reset in the middle of WAIT.
    eng_lat   = 4;
    req_valid = 1'b1;
    req_a     = 32'd100;
    req_b     = 32'd75;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    inject_done = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    inject_done = 1'b0;
    check_reset_values("mid_wait_reset");
    @(negedge clk);
    check_eq("rsp_valid_after_reset", rsp_valid, 0);
    txn(32'd100, 32'd75, 2, 32'd25, 4'd3, 1'b0, 5, 0);

    // Back-to-back with immediate response acceptance.
    txn(32'd30, 32'd12, 3, 32'd6, 4'd4, 1'b0, 6, 0);
    txn(32'd35, 32'd14, 1, 32'd7, 4'd2, 1'b0, 4, 0);
    txn(32'd81, 32'd27, 2, 32'd27, 4'd3, 1'b0, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Initiator-side front end for the GCD engine. It accepts operand pairs on a valid/ready request port and drives the engine's operand/start inputs. It waits for the engine's done pulse, captures the result, and presents it on a valid/ready response port together with a per-request cycle count. Zero operands are resolved locally without using the engine; an optional watchdog recovers from an engine that never completes.

## Interface
- WIDTH, 32, operand/result width; matches engine a_in/b_in/result
- TIMEOUT, 4096, WAIT cycles before a request is abandoned (watchdog builds only); ≥ 2
- CNT_W, 16, width of rsp_cycles
- clk  input  1  single clock; every flop is on posedge clk
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- req_valid  input  1  request operands valid
- req_ready  output  1  requester can accept a request
- req_a, req_b  input  WIDTH  operands
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_gcd  output  WIDTH  GCD result
- rsp_err  output  1  request timed out; rsp_gcd = 0
- rsp_cycles  output  CNT_W  cycles spent in WAIT, saturating
- eng_a, eng_b  output  WIDTH  to engine a_in/b_in
- eng_start  output  1  to engine start
- eng_result  input  WIDTH  from engine result
- eng_done  input  1  from engine done

## Operation
- States: IDLE, ISSUE, WAIT, HOLD. Reset → IDLE.
- **IDLE**: req_ready=1. On req_valid:
  - Latch req_a/req_b into eng_a/eng_b.
  - If either operand is 0, go to HOLD with rsp_gcd = req_a | req_b (gcd(0,x)=x, gcd(0,0)=0), rsp_cycles=0, rsp_err=0.
  - Otherwise go to ISSUE.
- **ISSUE**: eng_start=1 for exactly this cycle. Clear the cycle counter. Go to WAIT.
- **WAIT**: cycle counter increments each cycle and saturates at 2^CNT_W−1.
  - First cycle with eng_done=1: capture eng_result into rsp_gcd, capture the count into rsp_cycles, rsp_err=0, go to HOLD.
- **HOLD**: rsp_valid=1. rsp_gcd, rsp_err and rsp_cycles are stable. On rsp_ready, go to IDLE.
- eng_done is ignored in IDLE, ISSUE and HOLD. A stale or late done never produces a response.
- eng_a/eng_b hold their values from acceptance until the next acceptance.
- Arithmetic: the OR bypass is WIDTH bits. The counter is CNT_W bits, unsigned, and saturating with no wrap.

## Timing
- Reset values: req_ready=0 during reset, 1 in the cycle after reset deasserts. rsp_valid=0, rsp_err=0, eng_start=0, rsp_gcd=0, rsp_cycles=0, eng_a=0, eng_b=0.
- Request accepted at edge T:
  - eng_start=1 during cycle T+1.
  - WAIT from T+2.
  - eng_done seen at cycle D gives rsp_valid=1 from D+1.
- Bypass accepted at T: rsp_valid=1 from T+1.
- rsp_cycles counts WAIT cycles, including the done cycle. A done in the first WAIT cycle gives rsp_cycles=1.
- Response handshake at edge H: IDLE at H+1. Minimum 1 idle cycle between requests; no request is accepted while in HOLD.
- reset asserted in any state: the next cycle is IDLE with all reset values. The engine is reset by its own reset; done arriving during or after reset is ignored.

## Configuration
- GCD_REQ_TIMEOUT_EN defined:
  - WAIT aborts when the counter reaches TIMEOUT−1 with no eng_done.
  - Next state is HOLD with rsp_err=1, rsp_gcd=0 and rsp_cycles = min(TIMEOUT, saturation).
  - If done and timeout occur in the same cycle, done wins (rsp_err=0).
- GCD_REQ_TIMEOUT_EN undefined: WAIT waits indefinitely, rsp_err is tied 0, and the TIMEOUT parameter is unused.

## Structure
- Shared package gcd_pkg holds:
  - the state enum gcd_req_state_t (IDLE, ISSUE, WAIT, HOLD);
  - the default width constant GCD_WIDTH = 32.
- One sub-module, gcd_req_counter: clear, enable, saturating CNT_W counter with a compare output for TIMEOUT−1.

## Test plan
- a=48, b=18 against the real engine → eng_start one cycle after acceptance; response rsp_gcd=6, rsp_err=0, rsp_cycles equal to the observed WAIT length.
- a=0, b=7 → rsp_valid the cycle after acceptance, rsp_gcd=7, rsp_cycles=0, eng_start never asserted. Repeat with a=0, b=0 → rsp_gcd=0.
- a=17, b=5, rsp_ready held low 5 cycles after rsp_valid → rsp_gcd=1 stable all 5 cycles, req_ready=0, and extra eng_done pulses are ignored.
- Stub engine that never asserts done, GCD_REQ_TIMEOUT_EN, TIMEOUT=8 → HOLD after 8 WAIT cycles, rsp_err=1, rsp_gcd=0. A done injected later is ignored.
- reset pulsed for 1 cycle mid-WAIT of a=100, b=75 → IDLE next cycle, all outputs at reset values. A following a=100, b=75 request returns 25.
- Back-to-back requests with rsp_ready tied 1 → exactly one idle cycle between responses; eng_a/eng_b follow each accepted pair.
